// File: rtl/tribonacci_pkg.sv
// Shared definitions for the tribonacci generator and its monitor.
// Phase encodings and the three fixed start terms.
package tribonacci_pkg;

    typedef enum logic [2:0] {
        INIT0,
        INIT1,
        INIT2,
        RUN,
        HALT
    } phase_t;

    localparam int unsigned START0 = 0;
    localparam int unsigned START1 = 1;
    localparam int unsigned START2 = 1;

endpackage

// File: rtl/tribonacci_monitor_sync_fifo.sv
// Small synchronous FIFO; head entry drives dout directly.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo
    import tribonacci_pkg::*;
#(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] one = 1;

    logic [aw:0]      wptr;
    logic [aw:0]      rptr;
    logic [width-1:0] mem [depth];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[aw] != rptr[aw])
                && (wptr[aw-1:0] == rptr[aw-1:0]);
    assign dout  = mem[rptr[aw-1:0]];

    // A push into a full FIFO is legal only alongside a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[aw-1:0]] <= din;
                wptr <= wptr + one;
            end
            if (do_pop) begin
                rptr <= rptr + one;
            end
        end
    end

endmodule

// File: rtl/tribonacci_monitor.sv
// Checks the generator's term stream, flags errors and overflow,
// and buffers accepted terms for a slower consumer.
module tribonacci_monitor
    import tribonacci_pkg::*;
#(
    parameter int width     = 32,
    parameter int depth     = 4,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width-1:0]     s_in,
    output logic [width-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [cnt_width-1:0] term_idx,
    output logic                 seq_err,
    output logic                 ovf,
    output logic [cnt_width-1:0] drop_cnt
);

    localparam logic [cnt_width-1:0] cnt_one = 1;

    phase_t           phase;
    logic [width-1:0] h0;
    logic [width-1:0] h1;
    logic [width-1:0] h2;
    logic [width-1:0] expect_v;
    logic [width+1:0] sum;
    logic             sampling;
    logic             mismatch;
    logic             ovf_now;
    logic             accept;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;

    assign sum = {2'b00, h0} + {2'b00, h1} + {2'b00, h2};

    always_comb begin
        expect_v = sum[width-1:0];
        unique case (phase)
            INIT0:   expect_v = width'(START0);
            INIT1:   expect_v = width'(START1);
            INIT2:   expect_v = width'(START2);
            default: expect_v = sum[width-1:0];
        endcase
    end

    assign sampling = (phase != HALT);
    assign mismatch = sampling && (s_in != expect_v);
    assign ovf_now  = (phase == RUN) && (|sum[width+1:width]);
    assign accept   = sampling && !mismatch && !ovf_now;
    assign pop      = !empty && out_ready;
    assign push     = accept && (!full || pop);
    assign drop     = accept && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= INIT0;
            h0       <= '0;
            h1       <= '0;
            h2       <= '0;
            term_idx <= '0;
            seq_err  <= 1'b0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (sampling) begin
            h0 <= h1;
            h1 <= h2;
            h2 <= s_in;
            if (term_idx != '1) begin
                term_idx <= term_idx + cnt_one;
            end
            if (mismatch) begin
                seq_err <= 1'b1;
            end
            if (ovf_now) begin
                ovf <= 1'b1;
            end
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + cnt_one;
            end
            if (mismatch || ovf_now) begin
                phase <= HALT;
            end else begin
                unique case (phase)
                    INIT0:   phase <= INIT1;
                    INIT1:   phase <= INIT2;
                    default: phase <= RUN;
                endcase
            end
        end
    end

    sync_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (s_in),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_tribonacci_monitor.sv
// Scoreboard bench for tribonacci_monitor at width 8 and width 32.
// Expected terms are queued at stimulus time and popped by monitors.
module tb_tribonacci_monitor;

    localparam logic [31:0] trib [20] = '{
        32'd0,    32'd1,    32'd1,     32'd2,
        32'd4,    32'd7,    32'd13,    32'd24,
        32'd44,   32'd81,   32'd149,   32'd274,
        32'd504,  32'd927,  32'd1705,  32'd3136,
        32'd5768, 32'd10609, 32'd19513, 32'd35890
    };

    logic        clk = 1'b0;
    logic        rst8 = 1'b1;
    logic        rst32 = 1'b1;
    logic        rdy8 = 1'b0;
    logic        rdy32 = 1'b0;
    logic [7:0]  s8 = '0;
    logic [31:0] s32 = '0;
    logic [7:0]  od8;
    logic [31:0] od32;
    logic        ov8;
    logic        ov32;
    logic [15:0] idx8;
    logic [15:0] idx32;
    logic        err8;
    logic        err32;
    logic        ovf8;
    logic        ovf32;
    logic [15:0] drop8;
    logic [15:0] drop32;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  q8 [$];
    logic [31:0] q32 [$];

    always #5 clk = ~clk;

    tribonacci_monitor #(
        .width (8), .depth (4), .cnt_width (16)
    ) dut8 (
        .clk       (clk),
        .rst       (rst8),
        .s_in      (s8),
        .out_data  (od8),
        .out_valid (ov8),
        .out_ready (rdy8),
        .term_idx  (idx8),
        .seq_err   (err8),
        .ovf       (ovf8),
        .drop_cnt  (drop8)
    );

    tribonacci_monitor #(
        .width (32), .depth (4), .cnt_width (16)
    ) dut32 (
        .clk       (clk),
        .rst       (rst32),
        .s_in      (s32),
        .out_data  (od32),
        .out_valid (ov32),
        .out_ready (rdy32),
        .term_idx  (idx32),
        .seq_err   (err32),
        .ovf       (ovf32),
        .drop_cnt  (drop32)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    // Monitors: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst8 && ov8 && rdy8) begin
            if (q8.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL d8_unexpected: got %0d, expected none",
                         od8);
            end else begin
                check("d8_data", 32'(od8), 32'(q8.pop_front()));
            end
        end
        if (!rst32 && ov32 && rdy32) begin
            if (q32.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL d32_unexpected: got %0d, expected none",
                         od32);
            end else begin
                check("d32_data", od32, q32.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed8(input logic [7:0] v, input bit exp_push);
        s8 = v;
        if (exp_push) q8.push_back(v);
        step();
    endtask

    task automatic feed32(input logic [31:0] v, input bit exp_push);
        s32 = v;
        if (exp_push) q32.push_back(v);
        step();
    endtask

    task automatic reset32();
        rst32 = 1'b1;
        q32.delete();
        step();
        step();
        rst32 = 1'b0;
    endtask

    initial begin
        logic [31:0] t;

        step();
        check("d8_rst_valid", 32'(ov8), 32'd0);
        check("d8_rst_idx", 32'(idx8), 32'd0);
        check("d32_rst_data", od32, 32'd0);

        // width 8: overflow at term 11 (true sum 274, wrapped 18)
        rdy8 = 1'b1;
        rst8 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            t = trib[k];
            feed8(t[7:0], 1'b1);
        end
        feed8(8'd18, 1'b0);
        check("d8_ovf", 32'(ovf8), 32'd1);
        check("d8_idx", 32'(idx8), 32'd12);
        check("d8_err", 32'(err8), 32'd0);
        for (int k = 0; k < 3; k++) feed8(8'd42, 1'b0);
        check("d8_idx_halt", 32'(idx8), 32'd12);
        check("d8_q_empty", q8.size(), 32'd0);
        check("d8_valid_end", 32'(ov8), 32'd0);
        rst8 = 1'b1;

        // width 32: 20 clean terms, one per cycle
        reset32();
        rdy32 = 1'b1;
        feed32(trib[0], 1'b1);
        check("d32_latency", 32'(ov32), 32'd1);
        for (int k = 1; k < 20; k++) feed32(trib[k], 1'b1);
        check("d32_idx20", 32'(idx32), 32'd20);
        check("d32_ovf0", 32'(ovf32), 32'd0);
        check("d32_err0", 32'(err32), 32'd0);
        feed32(32'd0, 1'b0);
        check("d32_q_empty", q32.size(), 32'd0);

        // injected error at term 4
        reset32();
        for (int k = 0; k < 4; k++) feed32(trib[k], 1'b1);
        feed32(32'd5, 1'b0);
        check("err_set", 32'(err32), 32'd1);
        check("err_idx", 32'(idx32), 32'd5);
        check("err_ovf", 32'(ovf32), 32'd0);
        feed32(32'd7, 1'b0);
        check("err_halt_idx", 32'(idx32), 32'd5);
        check("err_sticky", 32'(err32), 32'd1);
        check("err_drop", 32'(drop32), 32'd0);

        // stalled consumer: fill, drop, then drain through a full FIFO
        reset32();
        rdy32 = 1'b0;
        for (int k = 0; k < 10; k++) feed32(trib[k], k < 4);
        check("stall_drop", 32'(drop32), 32'd6);
        check("stall_idx", 32'(idx32), 32'd10);
        check("stall_valid", 32'(ov32), 32'd1);
        check("stall_head", od32, 32'd0);
        rdy32 = 1'b1;
        feed32(trib[10], 1'b1);
        check("full_pushpop_drop", 32'(drop32), 32'd6);
        for (int k = 11; k < 20; k++) feed32(trib[k], 1'b1);
        check("full_drop_final", 32'(drop32), 32'd6);
        feed32(32'd0, 1'b0);
        for (int k = 0; k < 5; k++) step();
        check("drain_q_empty", q32.size(), 32'd0);
        check("drain_valid", 32'(ov32), 32'd0);

        // reset with FIFO non-empty
        reset32();
        rdy32 = 1'b0;
        for (int k = 0; k < 3; k++) feed32(trib[k], 1'b1);
        rst32 = 1'b1;
        q32.delete();
        #1;
        check("mid_rst_valid", 32'(ov32), 32'd0);
        check("mid_rst_data", od32, 32'd0);
        check("mid_rst_idx", 32'(idx32), 32'd0);
        check("mid_rst_drop", 32'(drop32), 32'd0);
        step();
        rst32 = 1'b0;
        rdy32 = 1'b1;
        feed32(trib[0], 1'b1);
        check("restart_idx", 32'(idx32), 32'd1);
        for (int k = 1; k < 4; k++) feed32(trib[k], 1'b1);
        check("restart_idx4", 32'(idx32), 32'd4);
        feed32(32'd0, 1'b0);
        step();
        check("restart_q_empty", q32.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
